// File: rtl/vga_pkg.sv
// Shared VGA raster constants: default 800x600@60 mode, totals,
// and a 640x480 alternate mode.
package vga_pkg;

  localparam int CW = 12;

  function automatic int mode_total(
    input int active,
    input int fp,
    input int sync,
    input int bp
  );
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;
  localparam bit DEF_HSYNC_POL = 1'b1;
  localparam bit DEF_VSYNC_POL = 1'b1;

  localparam int H_TOTAL = mode_total(
    DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int V_TOTAL = mode_total(
    DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_HSYNC_POL = 1'b0;
  localparam bit VGA640_VSYNC_POL = 1'b0;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with blank/sync flags registered
// from the next-state count so they line up with the count itself.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = 800,
  parameter int FP     = 40,
  parameter int SYNC   = 128,
  parameter int BP     = 88,
  parameter bit POL    = 1'b1
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          blank,
  output logic          sync,
  output logic          wrap
);

  localparam int TOTAL = mode_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
  localparam logic [CW-1:0] BLANK_ON = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_ON  = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_OFF = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] nxt;

  // Combinational tick: the next axis steps on the same edge
  assign wrap = en && (count == LAST);

  always_comb begin
    nxt = count;
    if (en) begin
      nxt = wrap ? '0 : count + CW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      blank <= 1'b0;
      sync  <= ~POL;
    end else begin
      count <= nxt;
      blank <= (nxt >= BLANK_ON);
      sync  <= ((nxt >= SYNC_ON) && (nxt < SYNC_OFF)) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: h/v counts, sync, blank and a
// frame-start pulse on every (last,last) -> (0,0) wrap.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = DEF_HSYNC_POL,
  parameter bit VSYNC_POL = DEF_VSYNC_POL
) (
  input  logic          clk_in,
  input  logic          rst_n,
  output logic [CW-1:0] hcount_out,
  output logic          hsync_out,
  output logic          hblnk_out,
  output logic [CW-1:0] vcount_out,
  output logic          vsync_out,
  output logic          vblnk_out,
  output logic          frame_start_out
);

  logic h_wrap;
  logic v_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL)
  ) u_h (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (1'b1),
    .count  (hcount_out),
    .blank  (hblnk_out),
    .sync   (hsync_out),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL)
  ) u_v (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (h_wrap),
    .count  (vcount_out),
    .blank  (vblnk_out),
    .sync   (vsync_out),
    .wrap   (v_wrap)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_out <= 1'b0;
    end else begin
      frame_start_out <= h_wrap && v_wrap;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Source of the VGA raster timing bundle consumed by every drawing stage in the video pipeline: background, puck and mallet overlays, and the final sync output. The block generates hcount/vcount, hsync/vsync and hblnk/vblnk for a parametrised mode; the default is 800x600 @ 60 Hz on the 40 MHz pixel clock. It also emits a one-cycle frame-start pulse that game logic uses to latch new object positions between frames.

## Interface
Parameters:
- H_ACTIVE, 800: visible pixels per line
- H_FP, 40: horizontal front porch, in pixels
- H_SYNC, 128: hsync width, in pixels
- H_BP, 88: horizontal back porch, in pixels
- V_ACTIVE, 600: visible lines per frame
- V_FP, 1: vertical front porch, in lines
- V_SYNC, 4: vsync width, in lines
- V_BP, 23: vertical back porch, in lines
- HSYNC_POL, 1: active level of hsync_out
- VSYNC_POL, 1: active level of vsync_out

Ports:
- clk_in  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- hcount_out  out  12  horizontal pixel index
- hsync_out  out  1  horizontal sync, at level HSYNC_POL when active
- hblnk_out  out  1  horizontal blanking
- vcount_out  out  12  line index
- vsync_out  out  1  vertical sync, at level VSYNC_POL when active
- vblnk_out  out  1  vertical blanking
- frame_start_out  out  1  one-cycle pulse on the cycle in which (hcount_out, vcount_out) become (0,0) by wrap

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628). Both must be ≤ 4096.
- Horizontal counter:
  - Increments every clk_in.
  - At H_TOTAL-1 it wraps to 0 and issues a line tick.
- Vertical counter:
  - Increments on the line tick.
  - At V_TOTAL-1 with a line tick, it wraps to 0.
- hblnk_out = 1 iff hcount_out ≥ H_ACTIVE.
- hsync active iff H_ACTIVE+H_FP ≤ hcount_out < H_ACTIVE+H_FP+H_SYNC (default 840..967).
- vblnk_out = 1 iff vcount_out ≥ V_ACTIVE.
- vsync active iff V_ACTIVE+V_FP ≤ vcount_out < V_ACTIVE+V_FP+V_SYNC (default 601..604).
- Every output is a flop. Flags are computed from the next-state counts, so flags and counts are coherent in the same cycle with zero skew.
- All counter and compare arithmetic is 12-bit unsigned. There are no signed operations.

## Timing
- Reset (rst_n=0, asynchronous) drives:
  - hcount_out=0, vcount_out=0
  - hblnk_out=0, vblnk_out=0
  - hsync_out=~HSYNC_POL, vsync_out=~VSYNC_POL
  - frame_start_out=0
- First rising edge after rst_n rises: hcount_out=1.
- The first frame after reset has no frame_start pulse. The first pulse comes at the first (H_TOTAL-1, V_TOTAL-1)→(0,0) wrap.
- Period: one line = H_TOTAL cycles; one frame = H_TOTAL·V_TOTAL cycles (663168 at defaults).
- Line wrap and frame wrap land on the same edge. vcount_out and hcount_out change together, and frame_start_out is high for exactly that one cycle.
- Reset asserted mid-frame: outputs return to reset values immediately, without waiting for a clock edge. Counting resumes from (0,0) on release.
- Handshake: none. The stream is free-running, and downstream stages add their own fixed latency to the whole bundle.

## Structure
- Shared package vga_pkg:
  - the default mode constants listed above
  - H_TOTAL and V_TOTAL
  - a localparam set for 640x480 as an alternate mode
- Sub-module vga_axis_counter:
  - parametrised by ACTIVE/FP/SYNC/BP/POL
  - inputs: clk_in, rst_n, and a count enable
  - outputs: count, blank, sync, wrap
  - instantiated twice: horizontal with enable tied to 1; vertical with enable driven by the horizontal wrap.
- frame_start_out is formed at top level from the two wraps.

## Test plan
- Reset: hold rst_n=0 for 5 cycles → all outputs at reset values, with hsync_out=vsync_out=0 at defaults. Release → hcount_out=1 after the first edge.
- Horizontal blank edge: hcount_out 799→800 → hblnk_out 0→1 in the same cycle as the count. hsync_out goes active at hcount_out=840 and inactive at 968.
- Line wrap: hcount_out=1055 → next cycle hcount_out=0, vcount_out increments by 1, and hblnk_out=0.
- Frame wrap: (1055,627) → (0,0) with frame_start_out=1 for one cycle. vsync_out is active only on lines 601–604, and vblnk_out only on lines 600–627. Measured frame period is 663168 cycles.
- Asynchronous reset mid-frame: drop rst_n at (300,200) between clock edges → outputs return to reset values before the next edge. Release → counting restarts at (0,0).
- Small mode (H 8/1/2/1, V 4/1/1/1, HSYNC_POL=0): hsync_out is low for hcount 9–10. The frame period is 12·7=84 cycles, and frame_start_out pulses every 84 cycles.
